reg_file: RTL and testbench
===========================

# reg_file

Parametrised multi-port register file for the simple processor datapath. It replaces single enable-gated registers with a DEPTH-entry array: one synchronous write port, two combinational read ports, optional write-to-read bypass, and a per-entry pending scoreboard for multi-cycle producers. A sequential clear engine zeroes the whole array without a global reset.

## Interface
Parameters:
- WIDTH, 16, data width in bits (≥1).
- DEPTH, 8, number of entries (power of two, ≥2); ADDR_W = $clog2(DEPTH).
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads show stored contents only.
- ZERO_R0, 0, 1 = entry 0 always reads 0, and writes and reserves to it are ignored.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- we_i  in  1  write enable.
- waddr_i  in  ADDR_W  write address.
- wdata_i  in  WIDTH  write data.
- raddr_a_i / raddr_b_i  in  ADDR_W  read addresses for ports A and B.
- rdata_a_o / rdata_b_o  out  WIDTH  read data (combinational).
- pend_a_o / pend_b_o  out  1  pending flag of the addressed entry (combinational).
- rsv_i  in  1  reserve request: mark an entry pending.
- rsv_addr_i  in  ADDR_W  entry to reserve.
- clr_i  in  1  start a sequential clear.
- busy_o  out  1  clear in progress; writes and reserves are ignored.

## Operation
- Reset (asynchronous): all entries 0, all pending flags 0, FSM in IDLE, clear counter 0, busy_o 0.
- Effective write (wr_eff):
  - Condition: we_i && !busy_o && !(ZERO_R0 && waddr_i==0).
  - On the rising edge: mem[waddr_i] <= wdata_i and pend[waddr_i] <= 0.
- Effective reserve (rsv_eff):
  - Condition: rsv_i && !busy_o && !(ZERO_R0 && rsv_addr_i==0).
  - On the rising edge: pend[rsv_addr_i] <= 1.
- Write and reserve to the same address in one cycle: data is written and pending ends at 1 (the reserve wins, for a new producer).
- Read, per port X:
  - If BYPASS && wr_eff && waddr_i==raddr_X_i: rdata = wdata_i and pend = 0.
  - Otherwise rdata = mem[raddr_X_i] and pend = pend[raddr_X_i].
  - If ZERO_R0 and raddr==0: rdata = 0 and pend = 0.
- Both read ports may address the same entry; each returns an identical result.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_i is sampled high. cnt <= 0.
  - In CLEAR, each edge: mem[cnt] <= 0, pend[cnt] <= 0, cnt <= cnt+1.
  - CLEAR -> IDLE on the edge that clears cnt==DEPTH-1; cnt wraps to 0.
  - busy_o = (state==CLEAR).
  - clr_i sampled in CLEAR is ignored; there is no restart.
  - A write or reserve in the same cycle clr_i is sampled in IDLE takes effect. The clear then overwrites it when it reaches that entry.
  - During CLEAR, reads return current contents: already-cleared entries read 0, the rest keep their old values.
- Reset asserted mid-clear: everything returns to the reset state immediately and the clear is abandoned.

## Timing
- Write latency: data is visible through a registered read on the cycle after the write edge. With BYPASS=1 it is visible combinationally in the same cycle.
- Reserve: pend_X_o goes high the cycle after the reserve edge.
- Clear, with clr_i sampled at edge k:
  - busy_o is high after edge k.
  - Entry i is zeroed at edge k+1+i.
  - busy_o falls after edge k+DEPTH; the clear takes DEPTH cycles.
  - The next write is accepted at edge k+DEPTH+1.
- Back-to-back writes: one per cycle, with no stall in IDLE.

## Test plan
- Reset then read: assert reset mid-cycle. All rdata = 0, all pend = 0 and busy_o = 0 immediately, without waiting for a clock edge.
- Write then read (WIDTH=16, DEPTH=8):
  - Write 0xBEEF to r3, then 0x1234 to r5.
  - Next cycle, raddr_a=3 and raddr_b=5 give 0xBEEF and 0x1234.
  - With BYPASS=1, raddr_a=3 during the write cycle gives 0xBEEF. With BYPASS=0 it gives the old value 0.
- Scoreboard:
  - Reserve r2: pend for r2 = 1 on the next cycle.
  - Write 0x00AA to r2: pend = 0 after the edge, and 0 in the same cycle if BYPASS=1.
  - Reserve and write r4 together: r4 = data and pend = 1.
- ZERO_R0=1: write 0xFFFF to r0 and reserve r0. r0 still reads 0 with pend = 0.
- Clear:
  - Fill r0..r7 with 0x1111·(i+1) and reserve r6, then pulse clr_i.
  - busy_o is high for exactly 8 cycles. Entries read 0 in order r0 to r7.
  - we_i asserted while busy has no effect. After busy_o falls, all entries are 0 and all pend are 0.
- Reset mid-clear: assert reset 3 cycles into the clear. busy_o = 0 and all entries are 0 immediately. After release, a write to r7 succeeds on the first edge.

Source files
------------

// File: rtl/reg_file_if.sv
// Bus bundle for reg_file: write port, two read ports, reserve port and clear control.
// The master drives requests and addresses; the slave (the register file) returns read data and status.
interface reg_file_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [WIDTH-1:0]  wdata_i;
  logic [ADDR_W-1:0] raddr_a_i;
  logic [ADDR_W-1:0] raddr_b_i;
  logic [WIDTH-1:0]  rdata_a_o;
  logic [WIDTH-1:0]  rdata_b_o;
  logic              pend_a_o;
  logic              pend_b_o;
  logic              rsv_i;
  logic [ADDR_W-1:0] rsv_addr_i;
  logic              clr_i;
  logic              busy_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_a_i, raddr_b_i, rsv_i, rsv_addr_i, clr_i,
    input  rdata_a_o, rdata_b_o, pend_a_o, pend_b_o, busy_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_a_i, raddr_b_i, rsv_i, rsv_addr_i, clr_i,
    output rdata_a_o, rdata_b_o, pend_a_o, pend_b_o, busy_o
  );
endinterface

// File: rtl/reg_file.sv
// Multi-port register file: one synchronous write port, two combinational read
// ports with optional write-to-read bypass, a per-entry pending scoreboard and a
// sequential clear engine that zeroes one entry per cycle.
module reg_file #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_if.slave     bus
);
  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [ADDR_W-1:0] r_cnt;

  logic              w_busy;
  logic              w_wr_eff;
  logic              w_rsv_eff;
  logic [ADDR_W-1:0] w_raddr [2];

  // Writes and reserves are locked out while clearing; entry 0 is read-only when hardwired to zero.
  assign w_busy    = (r_state == CLEAR);
  assign w_wr_eff  = bus.we_i  && !w_busy && !((ZERO_R0 != 0) && (bus.waddr_i    == '0));
  assign w_rsv_eff = bus.rsv_i && !w_busy && !((ZERO_R0 != 0) && (bus.rsv_addr_i == '0));
  assign bus.busy_o = w_busy;

  // Clear FSM next-state: start on clr_i from IDLE, return after the last entry is cleared.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.clr_i) w_state_next = CLEAR;
      CLEAR:   if (r_cnt == LAST_ADDR) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Clear counter walks every entry once; it wraps back to 0 naturally on the final step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_cnt <= '0;
    else if (w_busy)      r_cnt <= r_cnt + 1'b1;
    else if (bus.clr_i)   r_cnt <= '0;
  end

  // Data array: the clear engine owns the array while busy, otherwise the write port updates it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_eff) begin
      r_mem[bus.waddr_i] <= bus.wdata_i;
    end
  end

  // Pending scoreboard: a write retires the entry, a reserve marks it; the reserve is
  // applied last so a same-address write+reserve leaves the entry pending for the new producer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
    end else if (w_busy) begin
      r_pend[r_cnt] <= 1'b0;
    end else begin
      if (w_wr_eff)  r_pend[bus.waddr_i]    <= 1'b0;
      if (w_rsv_eff) r_pend[bus.rsv_addr_i] <= 1'b1;
    end
  end

  assign w_raddr[0] = bus.raddr_a_i;
  assign w_raddr[1] = bus.raddr_b_i;

  // Two identical read ports; each resolves bypass and the hardwired zero entry on its own.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [WIDTH-1:0] w_rd;
    logic             w_pd;

    // Read mux: stored value, overridden by the in-flight write, overridden by the zero entry.
    always_comb begin
      w_rd = r_mem[w_raddr[gi]];
      w_pd = r_pend[w_raddr[gi]];
      if ((BYPASS != 0) && w_wr_eff && (bus.waddr_i == w_raddr[gi])) begin
        w_rd = bus.wdata_i;
        w_pd = 1'b0;
      end
      if ((ZERO_R0 != 0) && (w_raddr[gi] == '0)) begin
        w_rd = '0;
        w_pd = 1'b0;
      end
    end
  end

  assign bus.rdata_a_o = g_rd[0].w_rd;
  assign bus.pend_a_o  = g_rd[0].w_pd;
  assign bus.rdata_b_o = g_rd[1].w_rd;
  assign bus.pend_b_o  = g_rd[1].w_pd;
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: two instances driven in lockstep, one with bypass and a
// writable r0, one without bypass and with r0 hardwired to zero.
module tb_reg_file;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          we = 1'b0, rsv = 1'b0, clr = 1'b0;
  logic [AW-1:0] waddr = '0, rsv_addr = '0, ra = '0, rb = '0;
  logic [W-1:0]  wdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  reg_file_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  reg_file_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

  assign bus0.we_i = we;        assign bus1.we_i = we;
  assign bus0.waddr_i = waddr;  assign bus1.waddr_i = waddr;
  assign bus0.wdata_i = wdata;  assign bus1.wdata_i = wdata;
  assign bus0.raddr_a_i = ra;   assign bus1.raddr_a_i = ra;
  assign bus0.raddr_b_i = rb;   assign bus1.raddr_b_i = rb;
  assign bus0.rsv_i = rsv;      assign bus1.rsv_i = rsv;
  assign bus0.rsv_addr_i = rsv_addr; assign bus1.rsv_addr_i = rsv_addr;
  assign bus0.clr_i = clr;      assign bus1.clr_i = clr;

  reg_file #(.WIDTH(W), .DEPTH(D), .BYPASS(1), .ZERO_R0(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  reg_file #(.WIDTH(W), .DEPTH(D), .BYPASS(0), .ZERO_R0(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          rsv;
    logic [AW-1:0] rsv_addr;
    logic [AW-1:0] ra, rb;
    logic [W-1:0]  a0; logic pa0; logic [W-1:0] b0; logic pb0;
    logic [W-1:0]  a1; logic pa1; logic [W-1:0] b1; logic pb1;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(input logic w, input int wa, input logic [W-1:0] wd,
                              input logic r, input int rsa, input int a, input int b,
                              input logic [W-1:0] a0, input logic pa0, input logic [W-1:0] b0, input logic pb0,
                              input logic [W-1:0] a1, input logic pa1, input logic [W-1:0] b1, input logic pb1);
    vec_t v;
    v.we = w; v.waddr = AW'(wa); v.wdata = wd; v.rsv = r; v.rsv_addr = AW'(rsa);
    v.ra = AW'(a); v.rb = AW'(b);
    v.a0 = a0; v.pa0 = pa0; v.b0 = b0; v.pb0 = pb0;
    v.a1 = a1; v.pa1 = pa1; v.b1 = b1; v.pb1 = pb1;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic busy,
                         input logic [W-1:0] a0, input logic pa0, input logic [W-1:0] b0, input logic pb0,
                         input logic [W-1:0] a1, input logic pa1, input logic [W-1:0] b1, input logic pb1);
    $display("%s %0d: ra=%0d rb=%0d a0=%h/%b b0=%h/%b a1=%h/%b b1=%h/%b busy=%b/%b", tag, idx, ra, rb,
             bus0.rdata_a_o, bus0.pend_a_o, bus0.rdata_b_o, bus0.pend_b_o,
             bus1.rdata_a_o, bus1.pend_a_o, bus1.rdata_b_o, bus1.pend_b_o, bus0.busy_o, bus1.busy_o);
    chk({tag, ".busy0"}, idx, W'(bus0.busy_o), W'(busy));
    chk({tag, ".busy1"}, idx, W'(bus1.busy_o), W'(busy));
    chk({tag, ".rdata_a0"}, idx, bus0.rdata_a_o, a0);
    chk({tag, ".pend_a0"},  idx, W'(bus0.pend_a_o), W'(pa0));
    chk({tag, ".rdata_b0"}, idx, bus0.rdata_b_o, b0);
    chk({tag, ".pend_b0"},  idx, W'(bus0.pend_b_o), W'(pb0));
    chk({tag, ".rdata_a1"}, idx, bus1.rdata_a_o, a1);
    chk({tag, ".pend_a1"},  idx, W'(bus1.pend_a_o), W'(pa1));
    chk({tag, ".rdata_b1"}, idx, bus1.rdata_b_o, b1);
    chk({tag, ".pend_b1"},  idx, W'(bus1.pend_b_o), W'(pb1));
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs are settled 2 units later.
  task automatic drive(input logic w, input int wa, input logic [W-1:0] wd, input logic r,
                       input int rsa, input logic c, input int a, input int b);
    @(negedge clk);
    we = w; waddr = AW'(wa); wdata = wd; rsv = r; rsv_addr = AW'(rsa); clr = c;
    ra = AW'(a); rb = AW'(b);
    #2;
  endtask

  initial begin
    logic [W-1:0] old_v;

    //     we wa wdata    rsv rsa ra rb   a0      pa0 b0      pb0   a1      pa1 b1      pb1
    vt[0]  = mk(0, 0, 16'h0000, 0, 0, 3, 5, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    vt[1]  = mk(1, 3, 16'hBEEF, 0, 0, 3, 5, 16'hBEEF, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    vt[2]  = mk(1, 5, 16'h1234, 0, 0, 3, 5, 16'hBEEF, 0, 16'h1234, 0, 16'hBEEF, 0, 16'h0000, 0);
    vt[3]  = mk(0, 0, 16'h0000, 0, 0, 3, 5, 16'hBEEF, 0, 16'h1234, 0, 16'hBEEF, 0, 16'h1234, 0);
    vt[4]  = mk(0, 0, 16'h0000, 1, 2, 2, 2, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    vt[5]  = mk(0, 0, 16'h0000, 0, 0, 2, 2, 16'h0000, 1, 16'h0000, 1, 16'h0000, 1, 16'h0000, 1);
    vt[6]  = mk(1, 2, 16'h00AA, 0, 0, 2, 3, 16'h00AA, 0, 16'hBEEF, 0, 16'h0000, 1, 16'hBEEF, 0);
    vt[7]  = mk(0, 0, 16'h0000, 0, 0, 2, 2, 16'h00AA, 0, 16'h00AA, 0, 16'h00AA, 0, 16'h00AA, 0);
    vt[8]  = mk(1, 4, 16'h5555, 1, 4, 4, 4, 16'h5555, 0, 16'h5555, 0, 16'h0000, 0, 16'h0000, 0);
    vt[9]  = mk(0, 0, 16'h0000, 0, 0, 4, 4, 16'h5555, 1, 16'h5555, 1, 16'h5555, 1, 16'h5555, 1);
    vt[10] = mk(1, 0, 16'hFFFF, 1, 0, 0, 0, 16'hFFFF, 0, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0);
    vt[11] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 1, 16'hFFFF, 1, 16'h0000, 0, 16'h0000, 0);
    vt[12] = mk(1, 1, 16'h0001, 0, 0, 1, 0, 16'h0001, 0, 16'hFFFF, 1, 16'h0000, 0, 16'h0000, 0);
    vt[13] = mk(1, 1, 16'h0002, 0, 0, 1, 0, 16'h0002, 0, 16'hFFFF, 1, 16'h0001, 0, 16'h0000, 0);
    vt[14] = mk(0, 0, 16'h0000, 0, 0, 1, 4, 16'h0002, 0, 16'h5555, 1, 16'h0002, 0, 16'h5555, 1);

    // Reset asserted mid-cycle, before any clock edge: outputs must clear at once.
    #1 reset = 1'b1;
    for (int i = 0; i < D; i++) begin
      ra = AW'(i); rb = AW'(D - 1 - i);
      #1;
      chk_all("reset", i, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Table-driven write / read / scoreboard / zero-entry vectors.
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].we, int'(vt[i].waddr), vt[i].wdata, vt[i].rsv, int'(vt[i].rsv_addr), 1'b0,
            int'(vt[i].ra), int'(vt[i].rb));
      chk_all("vec", i, 1'b0, vt[i].a0, vt[i].pa0, vt[i].b0, vt[i].pb0,
              vt[i].a1, vt[i].pa1, vt[i].b1, vt[i].pb1);
    end

    // Sequential clear: fill, reserve r6, pulse clr_i.
    for (int i = 0; i < D; i++) drive(1'b1, i, W'(16'h1111 * (i + 1)), 1'b0, 0, 1'b0, 0, 0);
    drive(1'b0, 0, '0, 1'b1, 6, 1'b0, 6, 0);
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 6, 0);
    chk_all("clr_start", 0, 1'b0, 16'h7777, 1'b1, 16'h1111, 1'b0, 16'h7777, 1'b1, 16'h0000, 1'b0);

    // Busy window: writes/reserves aimed at the next entry are ignored; a second clr_i is ignored.
    for (int j = 0; j < D; j++) begin
      drive(1'b1, (j + 1) % D, 16'hDEAD, 1'b1, (j + 1) % D, (j == 3), j, (j + D - 1) % D);
      old_v = W'(16'h1111 * (j + 1));
      chk_all("clearing", j, 1'b1,
              old_v, (j == 6), (j == 0) ? 16'h8888 : 16'h0000, 1'b0,
              (j == 0) ? 16'h0000 : old_v, (j == 6), (j == 0) ? 16'h8888 : 16'h0000, 1'b0);
    end

    // First cycle after busy falls: write accepted immediately.
    drive(1'b1, 3, 16'h7777, 1'b0, 0, 1'b0, 3, 0);
    chk_all("post_clr_wr", 0, 1'b0, 16'h7777, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 0, '0, 1'b0, 0, 1'b0, i, i);
      old_v = (i == 3) ? 16'h7777 : 16'h0000;
      chk_all("cleared", i, 1'b0, old_v, 1'b0, old_v, 1'b0, old_v, 1'b0, old_v, 1'b0);
    end

    // Reset abandons a clear in progress.
    drive(1'b1, 5, 16'hABCD, 1'b0, 0, 1'b0, 5, 7);
    drive(1'b1, 7, 16'h1357, 1'b0, 0, 1'b0, 5, 7);
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 5, 7);
    chk_all("rst_clr_pre", 0, 1'b0, 16'hABCD, 1'b0, 16'h1357, 1'b0, 16'hABCD, 1'b0, 16'h1357, 1'b0);
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 5, 7);
      chk_all("rst_clr_busy", j, 1'b1, 16'hABCD, 1'b0, 16'h1357, 1'b0, 16'hABCD, 1'b0, 16'h1357, 1'b0);
    end
    #3 reset = 1'b1;
    #1;
    chk_all("rst_mid_clr", 0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 7, 16'h2468, 1'b0, 0, 1'b0, 7, 5);
    chk_all("rst_wr7", 0, 1'b0, 16'h2468, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    drive(1'b0, 0, '0, 1'b0, 0, 1'b0, 7, 5);
    chk_all("rst_rd7", 0, 1'b0, 16'h2468, 1'b0, 16'h0000, 1'b0, 16'h2468, 1'b0, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
